// File: rtl/ifq_drain_if.sv
// ifq_drain_if: FIFO read port, flush, output handshake and debug counters of the drain controller
interface ifq_drain_if #(
  parameter int WIDTH = 32,
  parameter int CNT_WIDTH = 16
);
  logic fifo_empty;
  logic [WIDTH-1:0] fifo_rd_data;
  logic fifo_rd_en;
  logic flush;
  logic out_valid;
  logic [WIDTH-1:0] out_data;
  logic out_ready;
  logic [CNT_WIDTH-1:0] pop_count;
  logic [CNT_WIDTH-1:0] stall_count;
  modport master (
    input fifo_empty, fifo_rd_data, flush, out_ready,
    output fifo_rd_en, out_valid, out_data, pop_count, stall_count
  );
  modport slave (
    output fifo_empty, fifo_rd_data, flush, out_ready,
    input fifo_rd_en, out_valid, out_data, pop_count, stall_count
  );
endinterface

// File: rtl/ifq_drain.sv
// ifq_drain: pops a registered-read FIFO into a 2-entry skid buffer feeding a valid/ready output.
// Define IFQ_DRAIN_STALL_CNT_EN to build the saturating backpressure counter; otherwise stall_count is 0.
module ifq_drain #(
  parameter int WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input logic clk,
  input logic reset_n,
  ifq_drain_if.master bus
);
  typedef enum logic {RUN, DISCARD} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] buffer [2];
  logic [1:0] entries;
  logic head, tail, inflight, pop, push;
  logic [CNT_WIDTH-1:0] pcnt;
  always_comb begin
    pop = bus.out_valid & bus.out_ready;
    push = inflight & (state == RUN) & !bus.flush;
    state_nxt = (bus.flush & inflight) ? DISCARD : RUN;
  end
  // committed words plus the one in flight, net of this cycle's pop, must leave room
  assign bus.fifo_rd_en = reset_n & !bus.fifo_empty & !bus.flush &
                          (({1'b0, entries} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
  assign bus.out_valid = entries != 2'd0;
  assign bus.out_data = buffer[head];
  assign bus.pop_count = pcnt;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= RUN;
      entries <= '0;
      head <= 1'b0;
      tail <= 1'b0;
      inflight <= 1'b0;
      pcnt <= '0;
      buffer[0] <= '0;
      buffer[1] <= '0;
    end else begin
      state <= state_nxt;
      inflight <= bus.fifo_rd_en;
      pcnt <= pcnt + CNT_WIDTH'(pop);
      if (bus.flush) begin
        entries <= '0;
        head <= 1'b0;
        tail <= 1'b0;
      end else begin
        entries <= entries + 2'(push) - 2'(pop);
        head <= head ^ pop;
        tail <= tail ^ push;
        if (push) buffer[tail] <= bus.fifo_rd_data;
      end
    end
  end
`ifdef IFQ_DRAIN_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] scnt;
  always_ff @(posedge clk) begin
    if (!reset_n) scnt <= '0;
    else if (bus.out_valid & !bus.out_ready & ~&scnt) scnt <= scnt + 1'b1;
  end
  assign bus.stall_count = scnt;
`else
  assign bus.stall_count = '0;
`endif
endmodule

// File: doc/ifq_drain.md
# ifq_drain

Read-side drain controller for the instruction-queue FIFO. Pops words from a FIFO with a one-cycle registered read, absorbs that latency in a 2-entry skid buffer, and presents the words to the decode stage over a valid/ready handshake at one word per cycle. Supports a pipeline flush that discards all buffered and in-flight words, and keeps a popped-word counter for debug.

## Interface
- WIDTH, 32: data word width.
- CNT_WIDTH, 16: width of the debug counters.

- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_data  in  WIDTH  FIFO read data; valid the cycle after fifo_rd_en=1.
- fifo_rd_en  out  1  pop request to the FIFO (combinational).
- flush  in  1  discard all buffered and in-flight words.
- out_valid  out  1  out_data holds a word.
- out_data  out  WIDTH  head word of the skid buffer.
- out_ready  in  1  downstream accepts the word this cycle.
- pop_count  out  CNT_WIDTH  number of accepted output words; wraps.
- stall_count  out  CNT_WIDTH  backpressure cycles; see Configuration.

## Operation
- Skid buffer: 2 entries, circular head/tail pointers, occupancy `entries` in the range 0..2. out_valid = (entries != 0). out_data = buffer[head].
- inflight: a 1-bit register set on the cycle after fifo_rd_en=1. It marks that fifo_rd_data is valid.
- pop = out_valid & out_ready.
- fifo_rd_en = reset_n & !fifo_empty & !flush & (entries + inflight - pop < 2). This keeps throughput at 1 word/cycle when out_ready is held at 1.
- When inflight=1 and the FSM is in RUN, fifo_rd_data is written at tail. When a push and a pop happen in the same cycle, entries stays unchanged.
- FSM:
  - RUN: normal operation.
  - DISCARD: entered when flush=1 and either fifo_rd_en was 1 the previous cycle or inflight=1 this cycle. In DISCARD, the returning word is dropped and not written. The FSM goes back to RUN on the next cycle.
- Flush (cycle N):
  - A pop completing in cycle N counts as a transfer and increments pop_count.
  - entries, head and tail are cleared at the end of cycle N.
  - fifo_rd_en=0 during cycle N.
  - Any word returning in cycle N or N+1 from a read issued before the flush is dropped.
- pop_count increments on each pop and wraps modulo 2^CNT_WIDTH. Flush does not clear it.
- Reset has priority over flush. Flush has priority over push.

## Timing
- Reset values: out_valid=0, out_data=0, pop_count=0, stall_count=0, entries=0, inflight=0, FSM=RUN. fifo_rd_en=0 whenever reset_n=0.
- Latency: fifo_rd_en=1 in cycle T, data captured at the end of T+1, out_valid=1 in cycle T+2.
- out_data and out_valid are stable while out_valid=1 and out_ready=0.
- With entries=2 and out_ready=0, fifo_rd_en=0, and no word is lost.
- When fifo_empty goes to 1, fifo_rd_en drops in the same cycle. Buffered words keep draining.
- Reset asserted mid-stream: all state is cleared on the next edge, and the in-flight word is dropped.

## Configuration
- IFQ_DRAIN_STALL_CNT_EN defined: stall_count increments each cycle where out_valid=1 and out_ready=0. It saturates at all-ones and is cleared only by reset.
- IFQ_DRAIN_STALL_CNT_EN undefined: stall_count is tied to 0 and no counter logic is built.

## Test plan
- Hold reset_n=0 for 3 cycles with fifo_empty=0 and out_ready=1: fifo_rd_en=0, out_valid=0, pop_count=0, stall_count=0 throughout.
- FIFO holds 0x1..0x8, out_ready=1, reset released at cycle 0:
  - fifo_rd_en=1 in cycles 0–7.
  - out_valid=1 with out_data=0x1 at cycle 2, then 0x2..0x8 on consecutive cycles.
  - pop_count=8.
- Stream running, out_ready=0 for cycles 4–8:
  - entries=2, fifo_rd_en=0, out_data held.
  - After out_ready returns to 1, the sequence continues with no gap or duplicate.
  - stall_count=5 with the macro defined, 0 without it.
- flush=1 in the cycle after a read is issued:
  - The returning word is dropped and out_valid=0 the next cycle.
  - The next word read after the flush appears as the next out_data.
  - pop_count is unchanged apart from any pop in the flush cycle.
- Flush and pop in the same cycle with entries=2: pop_count increments by 1, and entries=0 afterwards.
- CNT_WIDTH=4, 17 accepted words: pop_count=1 (wrapped).
